rgmii_speed_ctrl: RTL and testbench

//  Link/speed controller for the RGMII PHY interface. Decodes RGMII in-band status from idle

---
 rtl/rgmii_speed_ctrl_pkg.sv | 25 ++
 rtl/rgmii_inband_decode.sv | 21 ++
 rtl/rgmii_speed_ctrl.sv | 113 +++++++++++
 tb/tb_rgmii_speed_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_speed_ctrl_pkg.sv
// rtl/rgmii_speed_ctrl_pkg.sv - RGMII in-band status encodings, field positions and controller states
package rgmii_speed_ctrl_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;
  localparam logic [1:0] SPEED_RSVD = 2'b11;

  localparam int LINK_BIT   = 0;
  localparam int SPEED_LSB  = 1;
  localparam int DUPLEX_BIT = 3;

  typedef enum logic [1:0] {
    S_RESET,
    S_DOWN,
    S_UP
  } state_t;

  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } status_t;

endpackage

// File: rtl/rgmii_inband_decode.sv
// rtl/rgmii_inband_decode.sv - combinational in-band status extraction from idle GMII receive cycles
module rgmii_inband_decode
  import rgmii_speed_ctrl_pkg::*;
(
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic       valid,
  output status_t    status
);

  assign status.link   = gmii_rxd[LINK_BIT];
  assign status.speed  = gmii_rxd[SPEED_LSB +: 2];
  assign status.duplex = gmii_rxd[DUPLEX_BIT];

  // Status is repeated in both nibbles on idle; anything else is frame data or noise.
  assign valid = !gmii_rx_dv && !gmii_rx_er &&
                 (gmii_rxd[3:0] == gmii_rxd[7:4]) &&
                 (status.speed != SPEED_RSVD);

endmodule

// File: rtl/rgmii_speed_ctrl.sv
// rtl/rgmii_speed_ctrl.sv - qualifies RGMII in-band status and drives speed, link and PHY interface reset
module rgmii_speed_ctrl
  import rgmii_speed_ctrl_pkg::*;
#(
  parameter int         STABLE_COUNT  = 16,
  parameter int         RST_PULSE_LEN = 8,
  parameter logic [1:0] DEFAULT_SPEED = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic       cfg_auto_en,
  input  logic [1:0] cfg_speed,
  output logic [1:0] speed,
  output logic       link_up,
  output logic       full_duplex,
  output logic       speed_change,
  output logic       phy_if_rst
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam int PW = $clog2(RST_PULSE_LEN + 1);

  logic          sample_valid;
  status_t       sample;
  status_t       cand;
  logic [CW-1:0] count;
  logic [1:0]    inband_speed;
  state_t        state;
  logic [PW-1:0] pulse_cnt;
  logic          commit;
  logic [1:0]    tgt_speed;
  logic          link_nxt;

  rgmii_inband_decode u_decode (
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .valid      (sample_valid),
    .status     (sample)
  );

  always_comb begin
    commit    = sample_valid && (sample == cand) && (count == CW'(STABLE_COUNT - 1));
    link_nxt  = commit ? sample.link : link_up;
    tgt_speed = inband_speed;
    if (cfg_auto_en) begin
      if (commit && sample.link) tgt_speed = sample.speed;
    end else if (cfg_speed != SPEED_RSVD) begin
      tgt_speed = cfg_speed;
    end else begin
      tgt_speed = speed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand  <= '0;
      count <= '0;
    end else if (sample_valid) begin
      if (sample == cand) begin
        if (count != CW'(STABLE_COUNT)) count <= count + 1'b1;
      end else begin
        cand  <= sample;
        count <= CW'(1);
      end
    end
  end

  // inband_speed remembers the last linked in-band speed so a return to auto mode can re-apply it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      pulse_cnt    <= PW'(RST_PULSE_LEN);
      phy_if_rst   <= 1'b1;
      speed        <= DEFAULT_SPEED;
      inband_speed <= DEFAULT_SPEED;
      link_up      <= 1'b0;
      full_duplex  <= 1'b0;
      speed_change <= 1'b0;
    end else begin
      speed_change <= 1'b0;
      if (commit) begin
        link_up     <= sample.link;
        full_duplex <= sample.link & sample.duplex;
        if (sample.link) inband_speed <= sample.speed;
      end
      if (tgt_speed != speed) begin
        speed        <= tgt_speed;
        speed_change <= 1'b1;
        phy_if_rst   <= 1'b1;
        pulse_cnt    <= PW'(RST_PULSE_LEN);
        state        <= S_RESET;
      end else begin
        case (state)
          S_RESET: begin
            if (pulse_cnt <= PW'(1)) begin
              phy_if_rst <= 1'b0;
              state      <= link_nxt ? S_UP : S_DOWN;
            end else begin
              pulse_cnt <= pulse_cnt - 1'b1;
            end
          end
          S_DOWN, S_UP: state <= link_nxt ? S_UP : S_DOWN;
          default:      state <= S_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// tb/tb_rgmii_speed_ctrl.sv - self-checking bench for rgmii_speed_ctrl with speed-change scoreboard
module tb_rgmii_speed_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       cfg_auto_en;
  logic [1:0] cfg_speed;
  logic [1:0] speed;
  logic       link_up;
  logic       full_duplex;
  logic       speed_change;
  logic       phy_if_rst;

  int         total = 0;
  int         bad   = 0;
  logic [1:0] exp_q[$];

  rgmii_speed_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .gmii_rxd     (gmii_rxd),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rx_er   (gmii_rx_er),
    .cfg_auto_en  (cfg_auto_en),
    .cfg_speed    (cfg_speed),
    .speed        (speed),
    .link_up      (link_up),
    .full_duplex  (full_duplex),
    .speed_change (speed_change),
    .phy_if_rst   (phy_if_rst)
  );

  always #5 clk = ~clk;

  // Every speed_change pulse must match the next expected speed queued by the stimulus.
  always @(negedge clk) begin
    if (speed_change === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_speed_change: got speed %0d want no pulse", speed);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (speed !== e) begin
          bad++;
          $display("FAIL speed_change_value: got %0d want %0d", speed, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    gmii_rxd   = 8'h00;
    gmii_rx_dv = 1'b1;
    gmii_rx_er = 1'b0;
  endtask

  task automatic count_rst(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (phy_if_rst === 1'b1) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    set_idle();
    cfg_auto_en = 1'b1;
    cfg_speed   = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (speed !== 2'b10) begin bad++; $display("FAIL reset_speed: got %0d want 2", speed); end
    if (link_up !== 1'b0) begin bad++; $display("FAIL reset_link: got %0b want 0", link_up); end
    if (phy_if_rst !== 1'b1) begin bad++; $display("FAIL reset_phy_rst: got %0b want 1", phy_if_rst); end
    if (speed_change !== 1'b0) begin bad++; $display("FAIL reset_speed_change: got %0b want 0", speed_change); end
    rst = 1'b0;
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL reset_pulse_len: got %0d want 8", n); end
  endtask

  task automatic test_autoneg();
    int n;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_q.push_back(2'b01);
      drive(8'hBB, 1'b0, 1'b0);
      if (i == 14) begin
        total++;
        if (speed !== 2'b10 || phy_if_rst !== 1'b0) begin
          bad++; $display("FAIL autoneg_early: got speed %0d rst %0b want 2 0", speed, phy_if_rst);
        end
      end
    end
    total += 3;
    if (speed !== 2'b01) begin bad++; $display("FAIL autoneg_speed: got %0d want 1", speed); end
    if (link_up !== 1'b1) begin bad++; $display("FAIL autoneg_link: got %0b want 1", link_up); end
    if (full_duplex !== 1'b1) begin bad++; $display("FAIL autoneg_duplex: got %0b want 1", full_duplex); end
    set_idle();
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL autoneg_pulse_len: got %0d want 8", n); end
  endtask

  task automatic test_requalify();
    int n;
    for (int i = 0; i < 15; i++) begin
      drive(8'hDD, 1'b0, 1'b0);
      if (i == 7) repeat (4) drive(8'hDD, 1'b1, 1'b0);
    end
    drive(8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 10) repeat (3) drive(8'hDD, 1'b0, 1'b1);
      if (i == 15) exp_q.push_back(2'b10);
      drive(8'hDD, 1'b0, 1'b0);
      if (i == 14) begin
        total++;
        if (speed !== 2'b01) begin bad++; $display("FAIL requal_early: got %0d want 1", speed); end
      end
    end
    total += 2;
    if (speed !== 2'b10) begin bad++; $display("FAIL requal_speed: got %0d want 2", speed); end
    if (link_up !== 1'b1 || full_duplex !== 1'b1) begin
      bad++; $display("FAIL requal_status: got link %0b dup %0b want 1 1", link_up, full_duplex);
    end
    set_idle();
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL requal_pulse_len: got %0d want 8", n); end
  endtask

  task automatic test_link_down();
    int n = 0;
    for (int i = 0; i < 16; i++) begin
      drive(8'h44, 1'b0, 1'b0);
      if (i == 14) begin
        total++;
        if (link_up !== 1'b1) begin bad++; $display("FAIL linkdown_early: got %0b want 1", link_up); end
      end
    end
    total += 2;
    if (link_up !== 1'b0 || full_duplex !== 1'b0) begin
      bad++; $display("FAIL linkdown_status: got link %0b dup %0b want 0 0", link_up, full_duplex);
    end
    if (speed !== 2'b10) begin bad++; $display("FAIL linkdown_speed: got %0d want 2", speed); end
    set_idle();
    repeat (10) begin
      @(negedge clk);
      if (phy_if_rst !== 1'b0) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL linkdown_phy_rst: got %0d high cycles want 0", n); end
  endtask

  task automatic test_invalid();
    repeat (32) drive(8'hFF, 1'b0, 1'b0);
    repeat (32) drive(8'h3D, 1'b0, 1'b0);
    total += 2;
    if (link_up !== 1'b0 || full_duplex !== 1'b0) begin
      bad++; $display("FAIL invalid_status: got link %0b dup %0b want 0 0", link_up, full_duplex);
    end
    if (speed !== 2'b10 || phy_if_rst !== 1'b0) begin
      bad++; $display("FAIL invalid_speed: got speed %0d rst %0b want 2 0", speed, phy_if_rst);
    end
  endtask

  task automatic test_manual();
    int n;
    set_idle();
    cfg_auto_en = 1'b0;
    cfg_speed   = 2'b10;
    repeat (3) drive(8'h00, 1'b1, 1'b0);
    cfg_speed = 2'b01;
    exp_q.push_back(2'b01);
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (speed !== 2'b01 || phy_if_rst !== 1'b1) begin
      bad++; $display("FAIL manual_first: got speed %0d rst %0b want 1 1", speed, phy_if_rst);
    end
    repeat (3) drive(8'h00, 1'b1, 1'b0);
    cfg_speed = 2'b00;
    exp_q.push_back(2'b00);
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (speed !== 2'b00) begin bad++; $display("FAIL manual_mid_reset: got %0d want 0", speed); end
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL manual_reload_len: got %0d want 8", n); end
    cfg_speed = 2'b11;
    repeat (5) drive(8'h00, 1'b1, 1'b0);
    total++;
    if (speed !== 2'b00) begin bad++; $display("FAIL manual_reserved: got %0d want 0", speed); end
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        cfg_speed = 2'b10;
        exp_q.push_back(2'b10);
      end
      drive(8'hBB, 1'b0, 1'b0);
    end
    total += 2;
    if (speed !== 2'b10) begin bad++; $display("FAIL manual_priority: got %0d want 2", speed); end
    if (link_up !== 1'b1 || full_duplex !== 1'b1) begin
      bad++; $display("FAIL manual_inband_status: got link %0b dup %0b want 1 1", link_up, full_duplex);
    end
    set_idle();
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL manual_priority_len: got %0d want 8", n); end
    cfg_auto_en = 1'b1;
    exp_q.push_back(2'b01);
    drive(8'h00, 1'b1, 1'b0);
    total++;
    if (speed !== 2'b01) begin bad++; $display("FAIL auto_return: got %0d want 1", speed); end
    count_rst(n);
    total++;
    if (n != 8) begin bad++; $display("FAIL auto_return_len: got %0d want 8", n); end
  endtask

  initial begin
    test_reset();
    test_autoneg();
    test_requalify();
    test_link_down();
    test_invalid();
    test_manual();
    repeat (4) drive(8'h00, 1'b1, 1'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
